apb_pvci_burst_seq: RTL and testbench

- APB slave sequencer that splits one 32-bit APB access into 8-bit PVCI byte cycles.
- Downstream it drives the byte-wide PVCI register port of the mcan2 CAN core; upstream it takes the APB peripheral-bus address window.
- Adds window/alignment error reporting (pslverr), pstrb byte masking, wait-state insertion (pready) and a configurable read-data latency.

---
 rtl/apb_pvci_seq_pkg.sv | 63 ++++++
 rtl/pvci_rd_capture.sv | 75 +++++++
 rtl/apb_pvci_burst_seq.sv | 194 +++++++++++++++++++
 tb/tb_apb_pvci_burst_seq.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pvci_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : apb_pvci_seq_pkg
// Description : Shared types, constants and lane helpers for the APB to
//               byte-wide PVCI burst sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package apb_pvci_seq_pkg;

    // Byte lanes in one 32-bit APB word and the PVCI port geometry.
    localparam int LANES   = 4;
    localparam int PVCI_AW = 8;
    localparam int PVCI_DW = 8;

    // Supported read-data latency range of the PVCI slave.
    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 3;

    typedef logic [$clog2(LANES)-1:0] lane_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT_RD = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    // Tag that travels down the read-capture pipeline with each issued read.
    typedef struct packed {
        logic  vld;
        lane_t lane;
        logic  last;
    } rd_tag_t;

    // Lowest set lane of a mask; the caller guarantees the mask is non-zero.
    function automatic lane_t first_lane(input logic [LANES-1:0] m);
        lane_t lane;
        lane = '0;
        for (int k = LANES - 1; k >= 0; k--) begin
            if (m[k]) lane = lane_t'(k);
        end
        return lane;
    endfunction

    function automatic logic [LANES-1:0] lane_onehot(input lane_t lane);
        logic [LANES-1:0] oh;
        oh       = '0;
        oh[lane] = 1'b1;
        return oh;
    endfunction

    function automatic logic [PVCI_DW-1:0] lane_byte(input logic [LANES*PVCI_DW-1:0] w,
                                                     input lane_t lane);
        logic [PVCI_DW-1:0] b;
        b = '0;
        for (int k = 0; k < LANES; k++) begin
            if (lane == lane_t'(k)) b = w[k*PVCI_DW +: PVCI_DW];
        end
        return b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pvci_rd_capture.sv
`default_nettype none
// ============================================================================
// Module      : pvci_rd_capture
// Description : Delays the lane tag of each PVCI read by the slave latency
//               and packs the returned byte into the 32-bit read register.
// Revision    : 1.0 - initial release
// ============================================================================
module pvci_rd_capture
    import apb_pvci_seq_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_issue,
    input  lane_t                    i_lane,
    input  logic                     i_last,
    input  logic                     i_clear,
    input  logic [PVCI_DW-1:0]       i_rdata,
    output logic [LANES*PVCI_DW-1:0] o_rdata,
    output logic                     o_last
);

    // Out-of-range latencies are pinned to the nearest supported value.
    localparam int c_lat = (RD_LAT < RD_LAT_MIN) ? RD_LAT_MIN :
                           (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT;

    rd_tag_t                  r_tag_q [c_lat];
    rd_tag_t                  w_tag_d [c_lat];
    rd_tag_t                  w_cap;
    logic [LANES*PVCI_DW-1:0] r_rdata_q;
    logic [LANES*PVCI_DW-1:0] w_rdata_d;

    // Tail stage holds the tag whose data is on i_rdata this cycle.
    assign w_cap   = r_tag_q[c_lat-1];
    assign o_last  = w_cap.vld & w_cap.last;
    assign o_rdata = r_rdata_q;

    // Tag pipeline: stage 0 takes the read issued this cycle.
    always_comb begin
        w_tag_d[0].vld  = i_issue;
        w_tag_d[0].lane = i_lane;
        w_tag_d[0].last = i_last;
        for (int i = 1; i < c_lat; i++) begin
            w_tag_d[i] = r_tag_q[i-1];
        end
    end

    // Byte packer: write the returned byte into its lane, or clear on a new access.
    always_comb begin
        w_rdata_d = r_rdata_q;
        if (i_clear) begin
            w_rdata_d = '0;
        end else if (w_cap.vld) begin
            for (int k = 0; k < LANES; k++) begin
                if (w_cap.lane == lane_t'(k)) w_rdata_d[k*PVCI_DW +: PVCI_DW] = i_rdata;
            end
        end
    end

    // Register stage for the tag pipeline and the packed read word.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < c_lat; i++) begin
                r_tag_q[i] <= '0;
            end
            r_rdata_q <= '0;
        end else begin
            r_tag_q   <= w_tag_d;
            r_rdata_q <= w_rdata_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/apb_pvci_burst_seq.sv
`default_nettype none
// ============================================================================
// Module      : apb_pvci_burst_seq
// Description : APB slave that splits each 32-bit access into byte cycles on
//               the PVCI register port of the CAN core, with window/alignment
//               error reporting, strobe masking and read-latency capture.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_pvci_burst_seq
    import apb_pvci_seq_pkg::*;
#(
    parameter logic [31:0] BASE_ADDRESS = 32'h1A10_8000,
    parameter int          WINDOW_BYTES = 256,
    parameter int          RD_LAT       = 1
) (
    input  logic               pclk,
    input  logic               preset,
    input  logic [31:0]        paddr,
    input  logic               pwrite,
    input  logic [31:0]        pwdata,
    input  logic [3:0]         pstrb,
    input  logic               psel,
    input  logic               penable,
    output logic [31:0]        prdata,
    output logic               pready,
    output logic               pslverr,
    output logic [PVCI_AW-1:0] pvci_addr,
    output logic [PVCI_DW-1:0] pvci_wd,
    output logic               pvci_valid,
    output logic               pvci_rd,
    input  logic [PVCI_DW-1:0] pvci_rdata
);

    localparam logic [31:0] c_window = 32'(WINDOW_BYTES);

    state_t             r_state_q,      w_state_d;
    logic [PVCI_AW-1:0] r_offset_q,     w_offset_d;
    logic               r_write_q,      w_write_d;
    logic [31:0]        r_wdata_q,      w_wdata_d;
    logic [LANES-1:0]   r_mask_q,       w_mask_d;
    lane_t              r_lane_q,       w_lane_d;
    logic               r_pready_q,     w_pready_d;
    logic               r_pslverr_q,    w_pslverr_d;
    logic               r_pvci_valid_q, w_pvci_valid_d;
    logic               r_pvci_rd_q,    w_pvci_rd_d;
    logic [PVCI_AW-1:0] r_pvci_addr_q,  w_pvci_addr_d;
    logic [PVCI_DW-1:0] r_pvci_wd_q,    w_pvci_wd_d;

    logic [31:0]        w_offset;
    logic               w_err;
    logic               w_setup;
    logic [LANES-1:0]   w_mask_in;
    lane_t              w_next_lane;
    logic               w_rd_clear;
    logic               w_rd_last;
    logic [31:0]        w_prdata;

    // Address decode; addresses below the base wrap to huge offsets and fail.
    assign w_offset  = paddr - BASE_ADDRESS;
    assign w_err     = (w_offset >= c_window) || (w_offset[1:0] != 2'b00);
    assign w_setup   = psel && !penable;
    assign w_mask_in = pwrite ? pstrb : {LANES{1'b1}};

    // Next-state and next-output logic. r_mask_q holds the lanes still to be
    // issued after the current one, so an empty mask marks the last lane.
    // A dropped psel is not watched: the burst runs to completion and the
    // one-cycle pready is simply ignored by the master.
    always_comb begin
        w_state_d      = r_state_q;
        w_offset_d     = r_offset_q;
        w_write_d      = r_write_q;
        w_wdata_d      = r_wdata_q;
        w_mask_d       = r_mask_q;
        w_lane_d       = r_lane_q;
        w_pready_d     = 1'b0;
        w_pslverr_d    = 1'b0;
        w_pvci_valid_d = 1'b0;
        w_pvci_rd_d    = 1'b0;
        w_pvci_addr_d  = '0;
        w_pvci_wd_d    = '0;
        w_rd_clear     = 1'b0;
        w_next_lane    = '0;
        case (r_state_q)
            ST_IDLE: begin
                if (w_setup) begin
                    w_offset_d = w_offset[PVCI_AW-1:0];
                    w_write_d  = pwrite;
                    w_wdata_d  = pwdata;
                    w_rd_clear = 1'b1;
                    if (w_err) begin
                        w_state_d   = ST_DONE;
                        w_pready_d  = 1'b1;
                        w_pslverr_d = 1'b1;
                    end else if (w_mask_in == '0) begin
                        w_state_d  = ST_DONE;
                        w_pready_d = 1'b1;
                    end else begin
                        w_next_lane    = first_lane(w_mask_in);
                        w_state_d      = ST_ISSUE;
                        w_lane_d       = w_next_lane;
                        w_mask_d       = w_mask_in & ~lane_onehot(w_next_lane);
                        w_pvci_valid_d = 1'b1;
                        w_pvci_rd_d    = !pwrite;
                        w_pvci_addr_d  = w_offset[PVCI_AW-1:0] + PVCI_AW'(w_next_lane);
                        w_pvci_wd_d    = lane_byte(pwdata, w_next_lane);
                    end
                end
            end
            ST_ISSUE: begin
                if (r_mask_q != '0) begin
                    w_next_lane    = first_lane(r_mask_q);
                    w_lane_d       = w_next_lane;
                    w_mask_d       = r_mask_q & ~lane_onehot(w_next_lane);
                    w_pvci_valid_d = 1'b1;
                    w_pvci_rd_d    = !r_write_q;
                    w_pvci_addr_d  = r_offset_q + PVCI_AW'(w_next_lane);
                    w_pvci_wd_d    = lane_byte(r_wdata_q, w_next_lane);
                end else if (r_write_q) begin
                    w_state_d  = ST_DONE;
                    w_pready_d = 1'b1;
                end else begin
                    w_state_d = ST_WAIT_RD;
                end
            end
            ST_WAIT_RD: begin
                if (w_rd_last) begin
                    w_state_d  = ST_DONE;
                    w_pready_d = 1'b1;
                end
            end
            ST_DONE: begin
                w_state_d = ST_IDLE;
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    // Sequencer state and registered bus outputs; reset abandons any burst.
    always_ff @(posedge pclk) begin
        if (preset) begin
            r_state_q      <= ST_IDLE;
            r_offset_q     <= '0;
            r_write_q      <= 1'b0;
            r_wdata_q      <= '0;
            r_mask_q       <= '0;
            r_lane_q       <= '0;
            r_pready_q     <= 1'b0;
            r_pslverr_q    <= 1'b0;
            r_pvci_valid_q <= 1'b0;
            r_pvci_rd_q    <= 1'b0;
            r_pvci_addr_q  <= '0;
            r_pvci_wd_q    <= '0;
        end else begin
            r_state_q      <= w_state_d;
            r_offset_q     <= w_offset_d;
            r_write_q      <= w_write_d;
            r_wdata_q      <= w_wdata_d;
            r_mask_q       <= w_mask_d;
            r_lane_q       <= w_lane_d;
            r_pready_q     <= w_pready_d;
            r_pslverr_q    <= w_pslverr_d;
            r_pvci_valid_q <= w_pvci_valid_d;
            r_pvci_rd_q    <= w_pvci_rd_d;
            r_pvci_addr_q  <= w_pvci_addr_d;
            r_pvci_wd_q    <= w_pvci_wd_d;
        end
    end

    pvci_rd_capture #(
        .RD_LAT (RD_LAT)
    ) u_rd_capture (
        .clk     (pclk),
        .rst     (preset),
        .i_issue (r_pvci_valid_q & r_pvci_rd_q),
        .i_lane  (r_lane_q),
        .i_last  (r_mask_q == '0),
        .i_clear (w_rd_clear),
        .i_rdata (pvci_rdata),
        .o_rdata (w_prdata),
        .o_last  (w_rd_last)
    );

    assign prdata     = w_prdata;
    assign pready     = r_pready_q;
    assign pslverr    = r_pslverr_q;
    assign pvci_addr  = r_pvci_addr_q;
    assign pvci_wd    = r_pvci_wd_q;
    assign pvci_valid = r_pvci_valid_q;
    assign pvci_rd    = r_pvci_rd_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_pvci_burst_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb_pvci_burst_seq
// Description : Directed bench for apb_pvci_burst_seq. Instance A uses a read
//               latency of 1, instance B a latency of 3; each has a PVCI slave
//               model returning addr+0x40 after its latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_pvci_burst_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] paddr;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic        psel_a, psel_b;
    logic        penable;

    logic [31:0] prdata_a, prdata_b;
    logic        pready_a, pready_b;
    logic        pslverr_a, pslverr_b;
    logic [7:0]  pvci_addr_a, pvci_addr_b;
    logic [7:0]  pvci_wd_a, pvci_wd_b;
    logic        pvci_valid_a, pvci_valid_b;
    logic        pvci_rd_a, pvci_rd_b;
    logic [7:0]  pvci_rdata_a = 8'hEE;
    logic [7:0]  pvci_rdata_b = 8'hEE;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    apb_pvci_burst_seq #(
        .BASE_ADDRESS (32'h1A10_8000),
        .WINDOW_BYTES (256),
        .RD_LAT       (1)
    ) dut_a (
        .pclk       (clk),
        .preset     (rst),
        .paddr      (paddr),
        .pwrite     (pwrite),
        .pwdata     (pwdata),
        .pstrb      (pstrb),
        .psel       (psel_a),
        .penable    (penable),
        .prdata     (prdata_a),
        .pready     (pready_a),
        .pslverr    (pslverr_a),
        .pvci_addr  (pvci_addr_a),
        .pvci_wd    (pvci_wd_a),
        .pvci_valid (pvci_valid_a),
        .pvci_rd    (pvci_rd_a),
        .pvci_rdata (pvci_rdata_a)
    );

    apb_pvci_burst_seq #(
        .BASE_ADDRESS (32'h1A10_8000),
        .WINDOW_BYTES (256),
        .RD_LAT       (3)
    ) dut_b (
        .pclk       (clk),
        .preset     (rst),
        .paddr      (paddr),
        .pwrite     (pwrite),
        .pwdata     (pwdata),
        .pstrb      (pstrb),
        .psel       (psel_b),
        .penable    (penable),
        .prdata     (prdata_b),
        .pready     (pready_b),
        .pslverr    (pslverr_b),
        .pvci_addr  (pvci_addr_b),
        .pvci_wd    (pvci_wd_b),
        .pvci_valid (pvci_valid_b),
        .pvci_rd    (pvci_rd_b),
        .pvci_rdata (pvci_rdata_b)
    );

    // PVCI slave models: history of {read issued, addr}; entry 0 is this cycle.
    // Data for a read issued in cycle Tk is presented so that it is sampled at
    // the end of cycle Tk+latency; otherwise the bus carries 0xEE.
    logic [8:0] hist_a [4] = '{default: '0};
    logic [8:0] hist_b [4] = '{default: '0};

    always @(negedge clk) begin
        hist_a[0] <= {pvci_valid_a & pvci_rd_a, pvci_addr_a};
        for (int i = 1; i < 4; i++) hist_a[i] <= hist_a[i-1];
        pvci_rdata_a <= hist_a[0][8] ? hist_a[0][7:0] + 8'h40 : 8'hEE;
    end

    always @(negedge clk) begin
        hist_b[0] <= {pvci_valid_b & pvci_rd_b, pvci_addr_b};
        for (int i = 1; i < 4; i++) hist_b[i] <= hist_b[i-1];
        pvci_rdata_b <= hist_b[2][8] ? hist_b[2][7:0] + 8'h40 : 8'hEE;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic setup(input int which, input logic [31:0] a, input logic w,
                         input logic [31:0] d, input logic [3:0] s);
        paddr   = a;
        pwrite  = w;
        pwdata  = d;
        pstrb   = s;
        penable = 1'b0;
        if (which == 0) psel_a = 1'b1;
        else            psel_b = 1'b1;
    endtask

    // Check one cycle that is not the completion cycle, then advance.
    task automatic cyc(input int which, input string tag, input logic v,
                       input logic [7:0] a, input logic [7:0] wd, input logic rd);
        logic       o_v, o_rd, o_rdy;
        logic [7:0] o_a, o_wd;
        o_v   = (which == 0) ? pvci_valid_a : pvci_valid_b;
        o_rd  = (which == 0) ? pvci_rd_a    : pvci_rd_b;
        o_rdy = (which == 0) ? pready_a     : pready_b;
        o_a   = (which == 0) ? pvci_addr_a  : pvci_addr_b;
        o_wd  = (which == 0) ? pvci_wd_a    : pvci_wd_b;
        chk({tag, "_valid"}, {31'd0, o_v}, {31'd0, v});
        if (v) begin
            chk({tag, "_addr"}, {24'd0, o_a}, {24'd0, a});
            chk({tag, "_rd"}, {31'd0, o_rd}, {31'd0, rd});
            if (!rd) chk({tag, "_wd"}, {24'd0, o_wd}, {24'd0, wd});
        end
        chk({tag, "_pready"}, {31'd0, o_rdy}, 32'd0);
        tick;
    endtask

    // Completion cycle checks, then release the bus and confirm a single pulse.
    task automatic fin(input int which, input string tag, input logic err,
                       input logic [31:0] rdata);
        chk({tag, "_done_valid"}, {31'd0, (which == 0) ? pvci_valid_a : pvci_valid_b}, 32'd0);
        chk({tag, "_done_pready"}, {31'd0, (which == 0) ? pready_a : pready_b}, 32'd1);
        chk({tag, "_done_pslverr"}, {31'd0, (which == 0) ? pslverr_a : pslverr_b}, {31'd0, err});
        chk({tag, "_done_prdata"}, (which == 0) ? prdata_a : prdata_b, rdata);
        tick;
        psel_a  = 1'b0;
        psel_b  = 1'b0;
        penable = 1'b0;
        chk({tag, "_after_pready"}, {31'd0, (which == 0) ? pready_a : pready_b}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired: observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst     = 1'b1;
        paddr   = '0;
        pwrite  = 1'b0;
        pwdata  = '0;
        pstrb   = '0;
        psel_a  = 1'b0;
        psel_b  = 1'b0;
        penable = 1'b0;
        tick;
        tick;
        chk("rst_pready", {31'd0, pready_a}, 32'd0);
        chk("rst_pslverr", {31'd0, pslverr_a}, 32'd0);
        chk("rst_valid", {31'd0, pvci_valid_a}, 32'd0);
        chk("rst_prdata", prdata_a, 32'd0);
        rst = 1'b0;
        tick;

        // Full-strobe write: four byte cycles, pready at T5.
        setup(0, 32'h1A10_8010, 1'b1, 32'hDDCC_BBAA, 4'hF);
        tick;
        penable = 1'b1;
        cyc(0, "w4_t1", 1'b1, 8'h10, 8'hAA, 1'b0);
        cyc(0, "w4_t2", 1'b1, 8'h11, 8'hBB, 1'b0);
        cyc(0, "w4_t3", 1'b1, 8'h12, 8'hCC, 1'b0);
        cyc(0, "w4_t4", 1'b1, 8'h13, 8'hDD, 1'b0);
        fin(0, "w4", 1'b0, 32'd0);

        // Sparse strobes skip lanes 1 and 3, pready at T3.
        setup(0, 32'h1A10_8020, 1'b1, 32'h4433_2211, 4'b0101);
        tick;
        penable = 1'b1;
        cyc(0, "w2_t1", 1'b1, 8'h20, 8'h11, 1'b0);
        cyc(0, "w2_t2", 1'b1, 8'h22, 8'h33, 1'b0);
        fin(0, "w2", 1'b0, 32'd0);

        // No strobes: no PVCI cycle, pready at T1.
        setup(0, 32'h1A10_8030, 1'b1, 32'h5555_5555, 4'b0000);
        tick;
        penable = 1'b1;
        fin(0, "w0", 1'b0, 32'd0);

        // Read with latency 1: pready at T6.
        setup(0, 32'h1A10_8004, 1'b0, 32'h1234_5678, 4'b0000);
        tick;
        penable = 1'b1;
        cyc(0, "rA_t1", 1'b1, 8'h04, 8'h00, 1'b1);
        cyc(0, "rA_t2", 1'b1, 8'h05, 8'h00, 1'b1);
        cyc(0, "rA_t3", 1'b1, 8'h06, 8'h00, 1'b1);
        cyc(0, "rA_t4", 1'b1, 8'h07, 8'h00, 1'b1);
        cyc(0, "rA_t5", 1'b0, 8'h00, 8'h00, 1'b0);
        fin(0, "rA", 1'b0, 32'h4746_4544);

        // Error responses at T1; prdata is cleared from the previous read.
        setup(0, 32'h1A10_8100, 1'b0, 32'h0, 4'hF);
        tick;
        penable = 1'b1;
        fin(0, "err_oow", 1'b1, 32'd0);
        setup(0, 32'h1A10_8002, 1'b1, 32'hFFFF_FFFF, 4'hF);
        tick;
        penable = 1'b1;
        fin(0, "err_misal", 1'b1, 32'd0);
        setup(0, 32'h1A10_7FFC, 1'b0, 32'h0, 4'hF);
        tick;
        penable = 1'b1;
        fin(0, "err_below", 1'b1, 32'd0);

        // Read with latency 3 on instance B: pready at T8, same data.
        setup(1, 32'h1A10_8004, 1'b0, 32'h0, 4'hF);
        tick;
        penable = 1'b1;
        cyc(1, "rB_t1", 1'b1, 8'h04, 8'h00, 1'b1);
        cyc(1, "rB_t2", 1'b1, 8'h05, 8'h00, 1'b1);
        cyc(1, "rB_t3", 1'b1, 8'h06, 8'h00, 1'b1);
        cyc(1, "rB_t4", 1'b1, 8'h07, 8'h00, 1'b1);
        cyc(1, "rB_t5", 1'b0, 8'h00, 8'h00, 1'b0);
        cyc(1, "rB_t6", 1'b0, 8'h00, 8'h00, 1'b0);
        cyc(1, "rB_t7", 1'b0, 8'h00, 8'h00, 1'b0);
        fin(1, "rB", 1'b0, 32'h4746_4544);

        // Reset in T2 of a write abandons the burst.
        setup(0, 32'h1A10_8000, 1'b1, 32'h0403_0201, 4'hF);
        tick;
        penable = 1'b1;
        cyc(0, "rstw_t1", 1'b1, 8'h00, 8'h01, 1'b0);
        chk("rstw_t2_valid", {31'd0, pvci_valid_a}, 32'd1);
        chk("rstw_t2_addr", {24'd0, pvci_addr_a}, 32'h01);
        rst = 1'b1;
        tick;
        chk("rstw_t3_valid", {31'd0, pvci_valid_a}, 32'd0);
        chk("rstw_t3_pready", {31'd0, pready_a}, 32'd0);
        rst     = 1'b0;
        psel_a  = 1'b0;
        penable = 1'b0;
        tick;
        chk("rstw_t4_valid", {31'd0, pvci_valid_a}, 32'd0);
        chk("rstw_t4_pready", {31'd0, pready_a}, 32'd0);
        setup(0, 32'h1A10_8000, 1'b1, 32'h0D0C_0B0A, 4'hF);
        tick;
        penable = 1'b1;
        cyc(0, "post_t1", 1'b1, 8'h00, 8'h0A, 1'b0);
        cyc(0, "post_t2", 1'b1, 8'h01, 8'h0B, 1'b0);
        cyc(0, "post_t3", 1'b1, 8'h02, 8'h0C, 1'b0);
        cyc(0, "post_t4", 1'b1, 8'h03, 8'h0D, 1'b0);
        fin(0, "post", 1'b0, 32'd0);

        // Back-to-back read then write with no idle cycle in between.
        setup(0, 32'h1A10_8008, 1'b0, 32'h0, 4'hF);
        tick;
        penable = 1'b1;
        cyc(0, "b2b_r_t1", 1'b1, 8'h08, 8'h00, 1'b1);
        cyc(0, "b2b_r_t2", 1'b1, 8'h09, 8'h00, 1'b1);
        cyc(0, "b2b_r_t3", 1'b1, 8'h0A, 8'h00, 1'b1);
        cyc(0, "b2b_r_t4", 1'b1, 8'h0B, 8'h00, 1'b1);
        cyc(0, "b2b_r_t5", 1'b0, 8'h00, 8'h00, 1'b0);
        chk("b2b_r_pready", {31'd0, pready_a}, 32'd1);
        chk("b2b_r_prdata", prdata_a, 32'h4B4A_4948);
        chk("b2b_r_pslverr", {31'd0, pslverr_a}, 32'd0);
        tick;
        setup(0, 32'h1A10_800C, 1'b1, 32'h8765_4321, 4'b1001);
        chk("b2b_gap_pready", {31'd0, pready_a}, 32'd0);
        chk("b2b_gap_valid", {31'd0, pvci_valid_a}, 32'd0);
        tick;
        penable = 1'b1;
        cyc(0, "b2b_w_t1", 1'b1, 8'h0C, 8'h21, 1'b0);
        cyc(0, "b2b_w_t2", 1'b1, 8'h0F, 8'h87, 1'b0);
        fin(0, "b2b_w", 1'b0, 32'd0);

        tick;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
